// File: rtl/mfp_ahb_bot_hub.sv
// AHB-Lite slave hub for N_BOTS Rojobot channels: wheel control, BotInfo shadows,
// update/ack handshake and a maskable IRQ. Define MFP_BOTHUB_TIMESTAMP_EN for per-channel update timestamps.
module mfp_ahb_bot_hub #(
    parameter int N_BOTS = 2,
    parameter int INFO_W = 32,
    parameter int CTRL_W = 8
) (
    input  logic                       HCLK,
    input  logic                       SI_Reset,
    input  logic                       HSEL,
    input  logic [7:0]                 HADDR,
    input  logic [1:0]                 HTRANS,
    input  logic                       HWRITE,
    input  logic [2:0]                 HSIZE,
    input  logic [31:0]                HWDATA,
    output logic [31:0]                HRDATA,
    output logic                       HREADYOUT,
    output logic [N_BOTS*CTRL_W-1:0]   IO_BotCtrl,
    input  logic [N_BOTS*INFO_W-1:0]   IO_BotInfo,
    input  logic [N_BOTS-1:0]          IO_BotUpdt_Sync,
    output logic [N_BOTS-1:0]          IO_INT_ACK,
    output logic                       BOT_IRQ
);

    localparam logic [1:0] REG_INFO   = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_STAT   = 2'd2;
    localparam logic [1:0] REG_TSTAMP = 2'd3;

    // Word addresses (HADDR[7:2]) of the global registers at 0xC0 / 0xC4.
    localparam logic [5:0] WORD_PEND   = 6'h30;
    localparam logic [5:0] WORD_IRQ_EN = 6'h31;

    logic                           accept;
    logic                           dphase_q;
    logic                           dwrite_q;
    logic [7:2]                     daddr_q;
    logic                           data_write;
    logic                           irq_en_we;

    logic [N_BOTS-1:0][INFO_W-1:0]  info_in;
    logic [N_BOTS-1:0][INFO_W-1:0]  info_q;
    logic [N_BOTS-1:0][CTRL_W-1:0]  ctrl_q;
    logic [N_BOTS-1:0][31:0]        tstamp_rd;
    logic [N_BOTS-1:0]              pending_q;
    logic [N_BOTS-1:0]              overrun_q;
    logic [N_BOTS-1:0]              irq_en_q;
    logic [N_BOTS-1:0]              updt_prev_q;
    logic [N_BOTS-1:0]              int_ack_q;

    logic [N_BOTS-1:0]              updt_edge;
    logic [N_BOTS-1:0]              ctrl_we;
    logic [N_BOTS-1:0]              stat_we;
    logic [N_BOTS-1:0]              ack_clr;
    logic [N_BOTS-1:0]              ovr_clr;
    logic [N_BOTS-1:0]              ovr_set;

    logic [31:0]                    rd_data;
    logic                           unused;

    // Every access is a word access; size and byte-lane bits carry no meaning here.
    assign unused    = ^{HSIZE, HTRANS[0], HADDR[1:0], HWDATA};
    assign HREADYOUT = 1'b1;
    assign accept    = HSEL & HTRANS[1];
    assign info_in   = IO_BotInfo;

    // ------------------------------------------------------------------
    // Address phase capture
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK) begin
        if (SI_Reset) begin
            dphase_q <= 1'b0;
            dwrite_q <= 1'b0;
            daddr_q  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            dphase_q <= accept;
            dwrite_q <= HWRITE;
            daddr_q  <= HADDR[7:2];
        end
    end

    // ------------------------------------------------------------------
    // Data-phase write decode
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
        ctrl_we    = '0;
        stat_we    = '0;
        data_write = dphase_q & dwrite_q;
        irq_en_we  = data_write && (daddr_q == WORD_IRQ_EN);
        for (int k = 0; k < N_BOTS; k++) begin
            if (data_write && (daddr_q[7:4] == 4'(k))) begin
                ctrl_we[k] = (daddr_q[3:2] == REG_CTRL);
                stat_we[k] = (daddr_q[3:2] == REG_STAT);
            end
        end
    end

    assign ack_clr = stat_we & {N_BOTS{HWDATA[0]}};
    assign ovr_clr = stat_we & {N_BOTS{HWDATA[1]}};

    // A new update on an unacknowledged channel is an overrun, unless this same
    // edge is acknowledging it: the ack consumes the old event, the new one stays pending.
    assign updt_edge = IO_BotUpdt_Sync & ~updt_prev_q;
    assign ovr_set   = updt_edge & pending_q & ~ack_clr;

    // ------------------------------------------------------------------
    // Per-channel state
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK) begin
        if (SI_Reset) begin
            // NOTE: prev regs reset high so a strobe held through reset is not seen as an edge.
            updt_prev_q <= '1;
            pending_q   <= '0;
            overrun_q   <= '0;
            int_ack_q   <= '0;
            irq_en_q    <= '0;
            info_q      <= '0;
            ctrl_q      <= '0;
        end else begin
            updt_prev_q <= IO_BotUpdt_Sync;
            pending_q   <= updt_edge | (pending_q & ~ack_clr);
            overrun_q   <= ovr_set | (overrun_q & ~ovr_clr);
            int_ack_q   <= ack_clr;
            if (irq_en_we) begin
                irq_en_q <= HWDATA[N_BOTS-1:0];
            end
            for (int k = 0; k < N_BOTS; k++) begin
                if (updt_edge[k]) begin
                    info_q[k] <= info_in[k];
                end
                if (ctrl_we[k]) begin
                    ctrl_q[k] <= HWDATA[CTRL_W-1:0];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional update timestamps
    // ------------------------------------------------------------------
`ifdef MFP_BOTHUB_TIMESTAMP_EN
    logic [31:0]             cycle_q;
    logic [N_BOTS-1:0][31:0] tstamp_q;

    always_ff @(posedge HCLK) begin
        if (SI_Reset) begin
            cycle_q  <= '0;
            tstamp_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            for (int k = 0; k < N_BOTS; k++) begin
                if (updt_edge[k]) begin
                    tstamp_q[k] <= cycle_q;
                end
            end
        end
    end

    assign tstamp_rd = tstamp_q;
`else
    assign tstamp_rd = '0;
`endif

    // ------------------------------------------------------------------
    // Read path: decoded from the live address phase
    // ------------------------------------------------------------------
    always_comb begin
        rd_data = '0;
        if (HADDR[7:2] == WORD_PEND) begin
            rd_data = 32'(pending_q);
        end else if (HADDR[7:2] == WORD_IRQ_EN) begin
            rd_data = 32'(irq_en_q);
        end else begin
            for (int k = 0; k < N_BOTS; k++) begin
                if (HADDR[7:4] == 4'(k)) begin
                    case (HADDR[3:2])
                        REG_INFO:   rd_data = 32'(info_q[k]);
                        REG_CTRL:   rd_data = 32'(ctrl_q[k]);
                        REG_STAT:   rd_data = {30'd0, overrun_q[k], pending_q[k]};
                        REG_TSTAMP: rd_data = tstamp_rd[k];
                        default:    rd_data = '0;
                    endcase
                end
            end
        end
    end

    // Read data is sampled at the address-phase edge, so a read issued right
    // behind a write to the same register returns the value before that write.
    always_ff @(posedge HCLK) begin
        if (SI_Reset) begin
            HRDATA <= '0;
        end else if (accept && !HWRITE) begin
            HRDATA <= rd_data;
        end
    end

    assign IO_BotCtrl = ctrl_q;
    assign IO_INT_ACK = int_ack_q;
    assign BOT_IRQ    = |(pending_q & irq_en_q);

endmodule

// File: tb/tb_mfp_ahb_bot_hub.sv
// Self-checking bench for mfp_ahb_bot_hub: directed register-map scenarios followed by
// randomized bus/update traffic, all compared against a register-level model.
module tb_mfp_ahb_bot_hub;

    localparam int N  = 2;
    localparam int IW = 32;
    localparam int CW = 8;

    logic              HCLK = 1'b0;
    logic              SI_Reset = 1'b1;
    logic              HSEL = 1'b0;
    logic [7:0]        HADDR = '0;
    logic [1:0]        HTRANS = '0;
    logic              HWRITE = 1'b0;
    logic [2:0]        HSIZE = 3'b010;
    logic [31:0]       HWDATA = '0;
    logic [31:0]       HRDATA;
    logic              HREADYOUT;
    logic [N*CW-1:0]   IO_BotCtrl;
    logic [N*IW-1:0]   IO_BotInfo = '0;
    logic [N-1:0]      IO_BotUpdt_Sync = '0;
    logic [N-1:0]      IO_INT_ACK;
    logic              BOT_IRQ;

    mfp_ahb_bot_hub #(.N_BOTS(N), .INFO_W(IW), .CTRL_W(CW)) dut (
        .HCLK            (HCLK),
        .SI_Reset        (SI_Reset),
        .HSEL            (HSEL),
        .HADDR           (HADDR),
        .HTRANS          (HTRANS),
        .HWRITE          (HWRITE),
        .HSIZE           (HSIZE),
        .HWDATA          (HWDATA),
        .HRDATA          (HRDATA),
        .HREADYOUT       (HREADYOUT),
        .IO_BotCtrl      (IO_BotCtrl),
        .IO_BotInfo      (IO_BotInfo),
        .IO_BotUpdt_Sync (IO_BotUpdt_Sync),
        .IO_INT_ACK      (IO_INT_ACK),
        .BOT_IRQ         (BOT_IRQ)
    );

    always #5 HCLK = ~HCLK;

    // Clock edges seen since reset was released.
    int unsigned cyc = 0;
    always @(posedge HCLK) cyc <= SI_Reset ? 0 : cyc + 1;

    // Register-level model
    logic [IW-1:0] info_m [N];
    logic [CW-1:0] ctrl_m [N];
    logic          pend_m [N];
    logic          ovr_m  [N];
    logic [31:0]   ts_m   [N];
    logic [N-1:0]  irqen_m;
    logic [31:0]   last_rd;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            info_m[i] = '0;
            ctrl_m[i] = '0;
            pend_m[i] = 1'b0;
            ovr_m[i]  = 1'b0;
            ts_m[i]   = '0;
        end
        irqen_m = '0;
        last_rd = '0;
    endtask

    function automatic logic [31:0] pend_vec();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i] = pend_m[i];
        return v;
    endfunction

    function automatic logic [31:0] exp_read(input logic [7:0] a);
        int ch;
        int rg;
        ch = int'(a[7:4]);
        rg = int'(a[3:2]);
        if (a == 8'hC0) return pend_vec();
        if (a == 8'hC4) return 32'(irqen_m);
        if (ch >= N) return '0;
        case (rg)
            0:       return info_m[ch];
            1:       return 32'(ctrl_m[ch]);
            2:       return {30'd0, ovr_m[ch], pend_m[ch]};
`ifdef MFP_BOTHUB_TIMESTAMP_EN
            default: return ts_m[ch];
`else
            default: return '0;
`endif
        endcase
    endfunction

    function automatic logic exp_irq();
        for (int i = 0; i < N; i++) if (pend_m[i] && irqen_m[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [N*CW-1:0] exp_ctrl();
        logic [N*CW-1:0] v;
        for (int i = 0; i < N; i++) v[i*CW +: CW] = ctrl_m[i];
        return v;
    endfunction

    // One clock edge of the model: optional bus write plus optional update strobes.
    task automatic model_step(input logic wr, input logic [7:0] a, input logic [31:0] d,
                              input logic [N-1:0] upd, input logic [N*IW-1:0] info);
        for (int i = 0; i < N; i++) begin
            logic hit_stat;
            logic clr0;
            logic clr1;
            logic set_ovr;
            hit_stat = wr && (int'(a[7:4]) == i) && (a[3:2] == 2'd2);
            clr0     = hit_stat && d[0];
            clr1     = hit_stat && d[1];
            set_ovr  = 1'b0;
            if (upd[i]) begin
                if (pend_m[i] && !clr0) set_ovr = 1'b1;
                pend_m[i] = 1'b1;
                info_m[i] = info[i*IW +: IW];
                ts_m[i]   = cyc - 1;
            end else if (clr0) begin
                pend_m[i] = 1'b0;
            end
            if (set_ovr) ovr_m[i] = 1'b1;
            else if (clr1) ovr_m[i] = 1'b0;
            if (wr && (int'(a[7:4]) == i) && (a[3:2] == 2'd1)) ctrl_m[i] = d[CW-1:0];
        end
        if (wr && a[7:2] == 6'h31) irqen_m = d[N-1:0];
    endtask

    task automatic check_outputs();
        check("bot_ctrl", 32'(IO_BotCtrl), 32'(exp_ctrl()));
        check("bot_irq", 32'(BOT_IRQ), 32'(exp_irq()));
    endtask

    task automatic idle_bus();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
    endtask

    // Single write; update strobes may be raised during its data phase.
    task automatic bus_write_upd(input logic [7:0] a, input logic [31:0] d,
                                 input logic [N-1:0] upd, input logic [N*IW-1:0] info);
        logic [N-1:0] exp_ack;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
        HSIZE = 3'($urandom_range(0, 2));
        @(posedge HCLK); #1;
        idle_bus();
        HWDATA = d;
        IO_BotInfo = info;
        IO_BotUpdt_Sync = upd;
        exp_ack = '0;
        for (int i = 0; i < N; i++)
            if ((int'(a[7:4]) == i) && (a[3:2] == 2'd2) && d[0]) exp_ack[i] = 1'b1;
        @(posedge HCLK); #1;
        IO_BotUpdt_Sync = '0;
        model_step(1'b1, a, d, upd, info);
        check("int_ack_pulse", 32'(IO_INT_ACK), 32'(exp_ack));
        check("hrdata_hold", HRDATA, last_rd);
        @(posedge HCLK); #1;
        check("int_ack_single", 32'(IO_INT_ACK), 32'd0);
        check_outputs();
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        bus_write_upd(a, d, '0, IO_BotInfo);
    endtask

    // Two writes issued back to back.
    task automatic bus_write_pair(input logic [7:0] a0, input logic [31:0] d0,
                                  input logic [7:0] a1, input logic [31:0] d1);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a0;
        @(posedge HCLK); #1;
        HADDR = a1; HWDATA = d0;
        @(posedge HCLK); #1;
        model_step(1'b1, a0, d0, '0, '0);
        idle_bus();
        HWDATA = d1;
        @(posedge HCLK); #1;
        model_step(1'b1, a1, d1, '0, '0);
        check_outputs();
    endtask

    task automatic read_check(input logic [7:0] a, input string tag);
        logic [31:0] exp;
        exp = exp_read(a);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
        @(posedge HCLK); #1;
        idle_bus();
        check(tag, HRDATA, exp);
        last_rd = exp;
        @(posedge HCLK); #1;
    endtask

    task automatic pulse(input logic [N-1:0] upd, input logic [N*IW-1:0] info);
        IO_BotInfo = info;
        IO_BotUpdt_Sync = upd;
        @(posedge HCLK); #1;
        IO_BotUpdt_Sync = '0;
        model_step(1'b0, 8'h00, 32'h0, upd, info);
        @(posedge HCLK); #1;
        check_outputs();
    endtask

    task automatic do_reset(input logic [N-1:0] hold);
        SI_Reset = 1'b1;
        idle_bus();
        IO_BotUpdt_Sync = hold;
        repeat (3) @(posedge HCLK);
        #1;
        SI_Reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N*IW-1:0] info;
        logic [N-1:0]    upd;
        logic [7:0]      a;
        int              op;
        int              ch;

        model_reset();
        // Reset with channel 1 strobe held high: it must not register as an update.
        do_reset(2'b10);
        check("rst_hrdata", HRDATA, 32'd0);
        check("rst_ack", 32'(IO_INT_ACK), 32'd0);
        check("hreadyout", 32'(HREADYOUT), 32'd1);
        check_outputs();
        repeat (3) @(posedge HCLK);
        #1;
        read_check(8'hC0, "held_strobe_pend");
        read_check(8'h18, "held_strobe_stat");
        IO_BotUpdt_Sync = '0;
        @(posedge HCLK); #1;
        for (int i = 0; i < 64; i++) read_check(8'(i * 4), "rst_reg_sweep");

        // Control registers, back-to-back writes, unmapped channel.
        bus_write_pair(8'h04, 32'h0000_00A5, 8'h14, 32'h0000_003C);
        check("ctrl_packed", 32'(IO_BotCtrl), 32'h0000_3CA5);
        read_check(8'h04, "ctrl0_read");
        read_check(8'h24, "unmapped_ch2");
        bus_write(8'h24, 32'hFFFF_FFFF);
        read_check(8'h24, "unmapped_write");

        // Update, interrupt, acknowledge on channel 0.
        info = '0;
        info[IW-1:0] = 32'h1234_5678;
        pulse(2'b01, info);
        bus_write(8'hC4, 32'h1);
        read_check(8'h00, "info0");
        read_check(8'h08, "stat0_pending");
        read_check(8'hC0, "pend_reg");
        check("irq_asserted", 32'(BOT_IRQ), 32'd1);
        bus_write(8'h08, 32'h1);
        check("irq_cleared", 32'(BOT_IRQ), 32'd0);

        // Overrun on channel 1, then clear only the overrun bit.
        info = '0;
        info[IW +: IW] = 32'hAAAA_0001;
        pulse(2'b10, info);
        info[IW +: IW] = 32'hBBBB_0002;
        pulse(2'b10, info);
        read_check(8'h18, "stat1_overrun");
        read_check(8'h10, "info1_latest");
        bus_write(8'h18, 32'h2);
        read_check(8'h18, "stat1_ovr_cleared");
        bus_write(8'h18, 32'h1);

        // Update edge coincident with ack: pending wins, no overrun, ack still pulses.
        info = '0;
        info[IW-1:0] = 32'hC0DE_0001;
        pulse(2'b01, info);
        info[IW-1:0] = 32'hC0DE_0002;
        bus_write_upd(8'h08, 32'h1, 2'b01, info);
        read_check(8'h08, "simul_stat");
        read_check(8'h00, "simul_info");

        // Both channels updated on the same edge.
        info = {32'h2222_0000, 32'h1111_0000};
        pulse(2'b11, info);
        read_check(8'hC0, "both_pend");
        read_check(8'h10, "both_info1");

        // Randomized traffic.
        for (int it = 0; it < 120; it++) begin
            op = $urandom_range(0, 4);
            ch = $urandom_range(0, 3);
            case (op)
                0: bus_write(8'(ch * 16 + 4), $urandom);
                1: begin
                    upd = N'($urandom_range(1, (1 << N) - 1));
                    for (int i = 0; i < N; i++) info[i*IW +: IW] = $urandom;
                    pulse(upd, info);
                end
                2: bus_write(8'(ch * 16 + 8), 32'($urandom_range(0, 3)));
                3: bus_write(8'hC4, $urandom);
                default: begin
                    if ($urandom_range(0, 4) == 0)
                        a = ($urandom_range(0, 1) == 1) ? 8'hC0 : 8'hC4;
                    else
                        a = 8'(ch * 16 + 4 * $urandom_range(0, 3));
                    read_check(a, "rand_read");
                end
            endcase
        end

`ifdef MFP_BOTHUB_TIMESTAMP_EN
        do_reset('0);
        for (int g = 0; g < 300 && cyc != 100; g++) begin
            @(posedge HCLK); #1;
        end
        check("ts_wait", cyc, 32'd100);
        info = '0;
        pulse(2'b01, info);
        read_check(8'h0C, "tstamp_model");
        check("tstamp_100", last_rd, 32'd100);
`else
        info = '0;
        pulse(2'b01, info);
        read_check(8'h0C, "tstamp_absent");
`endif

        // Reset during a write data phase aborts the write.
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 8'h04;
        @(posedge HCLK); #1;
        idle_bus();
        HWDATA = 32'h0000_00FF;
        SI_Reset = 1'b1;
        @(posedge HCLK); #1;
        SI_Reset = 1'b0;
        model_reset();
        @(posedge HCLK); #1;
        check("abort_ctrl", 32'(IO_BotCtrl), 32'd0);
        check("abort_hrdata", HRDATA, 32'd0);
        check_outputs();
        read_check(8'h04, "abort_ctrl_read");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
